// File: rtl/mem_arbiter.sv
// Serialises IF word fetches and MEM 1/2/4-byte loads/stores onto a single 8-bit RAM port.
// Optional MEMARB_RR_EN selects round-robin tie-breaking; otherwise MEM has fixed priority.
`timescale 1ns / 1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              busy
);
  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e            r_state;
  logic              r_owner_if;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_len;
  logic [2:0]        r_cnt;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic       w_if_pend;
  logic       w_grant_mem;
  logic       w_grant_if;
  logic [2:0] w_mem_len;
  logic [2:0] w_idx;
  logic [1:0] w_lane;
  logic [7:0] w_wbyte;

  assign w_if_pend = if_req && !if_flush;
  assign w_mem_len = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;

`ifdef MEMARB_RR_EN
  logic r_last_mem;
  assign w_grant_mem = mem_req && (!w_if_pend || !r_last_mem);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_mem <= 1'b0;
    end else if (rdy && r_state == StIdle && (w_grant_mem || w_grant_if)) begin
      r_last_mem <= w_grant_mem;
    end
  end
`else
  assign w_grant_mem = mem_req;
`endif
  assign w_grant_if = w_if_pend && !w_grant_mem;

  // Byte captured this cycle belongs to the address issued last cycle.
  assign w_lane = r_cnt[1:0] - 2'd1;
  // While stalled in RD, re-present the previous byte's address so ram_din still holds it on resume.
  assign w_idx  = (r_state == StRd && !rdy && r_cnt != 3'd0) ? r_cnt - 3'd1 : r_cnt;

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cnt[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_owner_if <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else if (rdy) begin
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_grant_mem) begin
            r_state    <= mem_we ? StWr : StRd;
            r_owner_if <= 1'b0;
            r_base     <= mem_addr;
            r_len      <= w_mem_len;
            r_wdata    <= mem_wdata;
            r_rdata    <= '0;
          end else if (w_grant_if) begin
            r_state    <= StRd;
            r_owner_if <= 1'b1;
            r_base     <= if_addr;
            r_len      <= 3'd4;
            r_wdata    <= '0;
            r_rdata    <= '0;
          end
        end
        StRd: begin
          if (r_owner_if && if_flush) begin
            r_state <= StIdle;
          end else begin
            if (r_cnt != 3'd0) r_rdata[{w_lane, 3'b000} +: 8] <= ram_din;
            if (r_cnt == r_len) r_state <= StDone;
            else r_cnt <= r_cnt + 3'd1;
          end
        end
        StWr: begin
          if (r_cnt == r_len - 3'd1) r_state <= StDone;
          else r_cnt <= r_cnt + 3'd1;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    if ((r_state == StRd || r_state == StWr) && w_idx < r_len) begin
      ram_a = r_base + ADDR_W'(w_idx);
    end
    if (r_state == StWr) begin
      ram_dout = w_wbyte;
      ram_wr   = rdy;
    end
  end

  assign if_done   = rdy && r_state == StDone && r_owner_if && !if_flush;
  assign mem_done  = rdy && r_state == StDone && !r_owner_if;
  assign if_data   = r_rdata;
  assign mem_rdata = r_rdata;
  assign busy      = r_state != StIdle;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential memory arbiter between the instruction-fetch stage and the MEM stage and the single 8-bit RAM port. It accepts 32-bit word fetches from IF and 1/2/4-byte loads and stores from MEM. It serialises each access into little-endian byte transfers on the RAM port and returns assembled data with a one-cycle done pulse. It sits between the IF and MEM stages and the top-level RAM interface, and replaces the combinational address mux.

## Interface
Parameters:
- ADDR_W, 32, address width of requester and RAM addresses.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes the block.
- if_req  in  1  IF fetch request; held until if_done or until if_flush.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  abandons any pending or active IF fetch.
- if_done  out  1  one-cycle pulse; if_data is valid in the same cycle.
- if_data  out  32  fetched word.
- mem_req  in  1  MEM request; held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  base byte address.
- mem_len  in  2  access size: 00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
- mem_wdata  in  32  store data; low bytes are used first.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  32  load data, zero-extended; valid while mem_done is high.
- ram_a  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write data.
- ram_wr  out  1  RAM write enable.
- ram_din  in  8  RAM read data; returns data for the ram_a of the previous cycle.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: requests are sampled here.
  - RD: read in progress.
  - WR: write in progress.
  - DONE: one cycle; done is pulsed here and requests are ignored.
- Grant in IDLE:
  - MEM wins over IF when both are pending (see Configuration).
  - A grant latches addr, len, wdata and owner; requester inputs are not re-read afterwards.
  - No preemption of a transfer in progress.
- Transfer length N: 1, 2 or 4 bytes for MEM; always 4 for IF.
- Byte addressing:
  - Byte i uses address base+i, computed modulo 2^ADDR_W (wrap-around permitted).
  - The counter cnt is 3 bits.
- RD:
  - Issues addresses for bytes 0..N-1 on consecutive cycles.
  - Captures ram_din into byte lane i one cycle after address i was issued.
  - Moves to DONE after byte N-1 is captured.
- WR:
  - Drives ram_a = base+i, ram_dout = wdata[8i+7:8i] and ram_wr = 1 for bytes 0..N-1.
  - Moves to DONE after byte N-1 is written.
- DONE:
  - Pulses the owner's done signal.
  - Read data is zero-extended above N bytes.
  - Returns to IDLE on the next edge.
- if_flush:
  - In RD with owner IF: abort on the next edge and return to IDLE; no if_done is issued.
  - In IDLE: if_req is ignored for that cycle.
  - In DONE with owner IF: if_done is suppressed.
  - Never affects a MEM transfer.
- rdy low:
  - All state, counters and data registers hold.
  - ram_wr is forced to 0 combinationally; done outputs are forced to 0.
  - Operation resumes exactly where it stopped.
- Outputs when idle: ram_a = 0, ram_dout = 0, ram_wr = 0.
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; if_data, mem_rdata and the latched registers cleared to 0. A reset mid-transfer drops the transfer with no done pulse.

## Timing
- Cycle 0 is the IDLE cycle with the request high; the grant is taken at the end of cycle 0.
- Read of N bytes:
  - Addresses appear in cycles 1..N.
  - The last byte is captured at the end of cycle N+1.
  - done is high in cycle N+2.
  - Fetch latency is 6 cycles request-to-done; a byte load is 3 cycles.
- Write of N bytes:
  - ram_wr is high in cycles 1..N.
  - done is high in cycle N+1.
- After a done cycle, the earliest next grant is at the end of the following IDLE cycle. Back-to-back fetches therefore complete every 7 cycles.
- Every low-rdy cycle extends latency by exactly one cycle.

## Configuration
- MEMARB_RR_EN:
  - Defined: round-robin. When both requests are pending in IDLE, grant goes to the requester not granted last. The last-owner flag resets to IF, so MEM wins the first tie.
  - Undefined: fixed priority; MEM always wins ties.

## Test plan
- Fetch: if_addr = 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a = 0x100..0x103 in cycles 1–4; if_done in cycle 6 with if_data = 0x00100513.
- Store half: mem_we = 1, len = 01, addr = 0x2000, wdata = 0xAABBCCDD -> ram_wr with (0x2000, 0xDD) then (0x2001, 0xCC); mem_done in cycle 3; no other writes.
- Simultaneous if_req and mem_req byte load:
  - Without macro: MEM is granted first, then IF is granted in the IDLE cycle after mem_done.
  - With MEMARB_RR_EN: a second simultaneous pair is granted to IF first.
- Assert if_flush in cycle 2 of a fetch -> FSM is IDLE in cycle 3; no if_done; a pending mem_req is granted at the end of cycle 3.
- Drop rdy for 3 cycles during byte 2 of a word store -> ram_wr = 0 while rdy is low; same byte resumes; mem_done 3 cycles late; 0xFFFFFFFF base wraps so byte 1 goes to 0x0.
- Pull rst_n low mid-read -> all outputs 0 immediately; no done; state IDLE.
